// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter: N-to-1 round-robin valid/ready merge with one registered output slice.
// Define HS_ARB_CNT_EN to add per-requester 16-bit accepted-beat counters on cnt_o.
module handshake_rr_arbiter #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    valid_i,
  input  logic [N*DW-1:0] data_i,
  output logic [N-1:0]    ready_o,
  output logic            valid_o,
  output logic [DW-1:0]   data_o,
  output logic [IW-1:0]   id_o,
  input  logic            ready_i
`ifdef HS_ARB_CNT_EN
  ,
  output logic [N*16-1:0] cnt_o
`endif
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt;
  logic [IW-1:0] g_hi;
  logic [IW-1:0] g_lo;
  logic          hit_hi;
  logic          load;
  logic          xfer;
  logic [DW-1:0] din;

  // Lowest valid index at or above ptr wins; otherwise lowest below ptr.
  always_comb begin
    hit_hi = 1'b0;
    g_hi   = '0;
    g_lo   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid_i[k]) begin
        if (IW'(k) >= ptr) begin
          hit_hi = 1'b1;
          g_hi   = IW'(k);
        end else begin
          g_lo = IW'(k);
        end
      end
    end
    gnt = hit_hi ? g_hi : g_lo;
  end

  assign load = !valid_o || ready_i;

  always_comb begin
    ready_o = '0;
    if (load && |valid_i && !rst)
      ready_o[gnt] = 1'b1;
  end

  assign xfer = |ready_o;

  always_comb begin
    din = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt == IW'(k))
        din = data_i[k*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      id_o    <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      valid_o <= 1'b1;
      data_o  <= din;
      id_o    <= gnt;
      ptr     <= (gnt == IW'(N - 1)) ? '0 : gnt + IW'(1);
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

`ifdef HS_ARB_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_o <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (ready_o[k])
          cnt_o[k*16 +: 16] <= cnt_o[k*16 +: 16] + 16'd1;
      end
    end
  end
`else
  // Counters are not built; the merge path is unchanged.
`endif

endmodule

// File: doc/handshake_rr_arbiter.md
# handshake_rr_arbiter

Round-robin arbiter that merges N valid/ready producer channels onto one valid/ready consumer channel. It has a single registered output slice, so a downstream consumer sees one registered beat stream tagged with the source index. It sits between several Handshake_Sender-style producers and a shared bridge or receiver stage. It sustains one beat per cycle and gives each active requester a fair share.

## Interface
Parameters:
- N, 4, number of requesters (2..16, need not be a power of two)
- DW, 8, data width per beat
- IW, $clog2(N), width of source-index tag

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- valid_i  input  N  per-requester valid, bit k = requester k
- data_i  input  N*DW  per-requester data, requester k at bits [k*DW +: DW]
- ready_o  output  N  per-requester ready, at most one bit high
- valid_o  output  1  registered output valid
- data_o  output  DW  registered output data
- id_o  output  IW  index of requester that produced the current beat
- ready_i  input  1  consumer ready
- cnt_o  output  N*16  per-requester accepted-beat counters (only with HS_ARB_CNT_EN)

## Operation
- State: output register {valid_o, data_o, id_o}; round-robin pointer ptr (IW bits, range 0..N-1).
- load = !valid_o || ready_i. The slice can take a beat when it is empty or draining this cycle.
- Grant g is the first k with valid_i[k]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
- ready_o[g] = load && |valid_i && !rst. All other ready_o bits are 0. If there is no valid input, ready_o = 0.
- An upstream transfer happens when valid_i[g] && ready_o[g]. On that edge:
  - data_o <= data_i[g], id_o <= g, valid_o <= 1.
  - ptr <= (g == N-1) ? 0 : g+1.
- Output drains when valid_o && ready_i. If no upstream transfer happens on the same edge, valid_o <= 0 and data_o/id_o hold their values.
- When load = 0 (valid_o && !ready_i): all ready_o are 0, and the output register and ptr hold.
- ptr moves only on an upstream transfer. A grant that changes without a transfer is legal because producers hold valid/data until accepted.
- No beat is dropped, duplicated or reordered within one requester.

## Timing
- Reset (rst=1 at an edge): valid_o=0, data_o=0, id_o=0, ptr=0, cnt_o=0. ready_o is forced to 0 while rst=1.
- Latency: a beat accepted at edge t appears on valid_o/data_o/id_o after edge t, and the consumer can accept it at edge t+1.
- Throughput: with ready_i held high and any valid_i high, one beat is transferred every cycle.
- Combinational paths: ready_i→ready_o and valid_i→ready_o. There is no combinational path to valid_o or data_o.
- Simultaneous drain and load on the same edge: the new beat replaces the old one and valid_o stays 1.
- Wrap: when g=N-1, ptr becomes 0. For non-power-of-two N, ptr never takes a value ≥ N.
- Single active requester: it is granted every cycle whatever ptr holds.
- Reset during traffic: any beat in the output register is discarded and valid_o falls after the reset edge. Upstream producers must retain unaccepted beats.

## Configuration
- HS_ARB_CNT_EN defined:
  - cnt_o is present.
  - Counter k increments by 1 on each upstream transfer from requester k, wraps at 2^16, and is cleared by rst.
- HS_ARB_CNT_EN undefined:
  - The cnt_o port and counters are absent.
  - All other behaviour is identical.

## Test plan
- Reset: hold rst=1 for 5 cycles with all valid_i=1 → ready_o=0, valid_o=0, data_o=0, id_o=0 throughout. First grant after release goes to requester 0.
- Full contention: N=4, all valid_i=1, ready_i=1, each producer sending an incrementing sequence → id_o sequence 0,1,2,3,0,1,… with one beat per cycle and per-requester data in order.
- Backpressure: ready_i=0 for 3 cycles with valid_o=1 → ready_o=0 and data_o/id_o stable. On ready_i=1, the held beat transfers and the next grant follows ptr.
- Sparse and wrap: only requesters 3 and 1 valid, ptr=2 → grant order 3, 1, 3, 1. A single requester 2 alone is granted every cycle.
- Random stall: each producer emits 1..200, with random valid stall on producers and random ready_i → every producer's stream arrives complete and in order (checked per id_o) and there are no errors. With HS_ARB_CNT_EN, every cnt_o entry equals 200.
- Mid-traffic reset: assert rst for one cycle while valid_o=1 → valid_o=0 the next cycle, ptr=0, counters cleared, and traffic resumes correctly.
